// File: rtl/slt_pkg.sv
// Shared constants, FSM state type and id-width helper for the SLT arbiter slice.
package slt_pkg;

    localparam int unsigned SLT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } slt_arb_state_t;

    function automatic int unsigned slt_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slt_compare.sv
// Combinational set-less-than: lt_o = (a_i < b_i), signed or unsigned.
module slt_compare
    import slt_pkg::*;
#(
    parameter int unsigned WIDTH = SLT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_i,
    output logic             lt_o
);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] diff;
    logic           unused_diff;

    // One extra bit keeps the true sign of the difference even on signed overflow.
    always_comb begin
        ext_a = {signed_i & a_i[WIDTH-1], a_i};
        ext_b = {signed_i & b_i[WIDTH-1], b_i};
        diff  = ext_a - ext_b;
        lt_o  = diff[WIDTH];
    end

    assign unused_diff = ^diff[WIDTH-1:0];

endmodule

// File: rtl/slt_arbiter.sv
// Shares one SLT compare unit among NUM_REQ requesters, one transaction in flight.
// Define SLT_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module slt_arbiter
    import slt_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = SLT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]         req_a,
    input  logic [NUM_REQ*WIDTH-1:0]         req_b,
    input  logic [NUM_REQ-1:0]               req_signed,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic                             resp_res,
    output logic [slt_id_width(NUM_REQ)-1:0] resp_id,
    output logic                             busy
);

    localparam int unsigned IdW = slt_id_width(NUM_REQ);
    typedef logic [IdW-1:0] id_t;

    slt_arb_state_t   state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    id_t              id_q, id_d;
    logic             res_q, res_d;
    logic             resp_valid_q, resp_valid_d;
    id_t              grant_id;
    logic             grant_vld;
    logic             cmp_lt;
    logic             accept;

`ifdef SLT_ARB_RR_EN
    id_t ptr_q, ptr_d;

    // First valid index strictly after the last grant, wrapping.
    always_comb begin
        id_t cand;
        cand      = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = id_t'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = grant_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= id_t'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_id  = '0;
        grant_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[id_t'(i)]) begin
                grant_vld = 1'b1;
                grant_id  = id_t'(i);
            end
        end
    end
`endif

    assign accept = (state_q == IDLE) && grant_vld;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    slt_compare #(
        .WIDTH (WIDTH)
    ) u_slt_compare (
        .a_i      (a_q),
        .b_i      (b_q),
        .signed_i (sgn_q),
        .lt_o     (cmp_lt)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sgn_d        = sgn_q;
        id_d         = id_q;
        res_d        = res_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d     = req_a[32'(grant_id) * WIDTH +: WIDTH];
                    b_d     = req_b[32'(grant_id) * WIDTH +: WIDTH];
                    sgn_d   = req_signed[grant_id];
                    id_d    = grant_id;
                    state_d = CMP;
                end
            end
            CMP: begin
                res_d        = cmp_lt;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sgn_q        <= 1'b0;
            id_q         <= '0;
            res_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sgn_q        <= sgn_d;
            id_q         <= id_d;
            res_q        <= res_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_res   = res_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_slt_arbiter.sv
// Directed bench for slt_arbiter: vector table plus stall, reset and arbitration sequences.
module tb_slt_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_signed;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_res;
    logic [1:0]     resp_id;
    logic           busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic        exp_res;
    } vec_t;

    vec_t vecs[9];

    slt_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_res   (resp_res),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic sgn);
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_signed[i]    = sgn;
    endtask

    task automatic apply_reset();
        req_valid  = '0;
        resp_ready = 1'b1;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Other slots get swapped operands so a wrong selection yields a wrong result.
    task automatic do_txn(input vec_t v, input string tag);
        logic [N-1:0] onehot;
        onehot = '0;
        onehot[v.req] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) set_slot(i, v.b, v.a, ~v.sgn);
        set_slot(v.req, v.a, v.b, v.sgn);
        req_valid = onehot;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(onehot));
        check({tag, "_idle_busy"}, 32'(busy), 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        set_slot(v.req, v.b, v.a, ~v.sgn);
        check({tag, "_cmp_ready"}, 32'(req_ready), 0);
        check({tag, "_cmp_busy"}, 32'(busy), 1);
        check({tag, "_cmp_valid"}, 32'(resp_valid), 0);
        @(posedge clk);
        #1;
        check({tag, "_resp_valid"}, 32'(resp_valid), 1);
        check({tag, "_resp_res"}, 32'(resp_res), 32'(v.exp_res));
        check({tag, "_resp_id"}, 32'(resp_id), 32'(v.req));
        @(posedge clk);
        #1;
        check({tag, "_done_valid"}, 32'(resp_valid), 0);
        check({tag, "_done_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int got;
        int last;
        int n;
        int seen;
        int exp_ids[5];

        vecs[0] = '{0, 32'd49,         32'd67,         1'b0, 1'b1};
        vecs[1] = '{1, 32'hFFFF_FFFF,  32'd1,          1'b1, 1'b1};
        vecs[2] = '{2, 32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0};
        vecs[3] = '{3, 32'h7FFF_FFFF,  32'h8000_0000,  1'b1, 1'b0};
        vecs[4] = '{0, 32'h7FFF_FFFF,  32'h8000_0000,  1'b0, 1'b1};
        vecs[5] = '{1, 32'd5,          32'd5,          1'b1, 1'b0};
        vecs[6] = '{2, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1, 1'b1};
        vecs[7] = '{3, 32'h8000_0000,  32'h8000_0001,  1'b1, 1'b1};
        vecs[8] = '{0, 32'd67,         32'd49,         1'b0, 1'b0};

`ifdef SLT_ARB_RR_EN
        exp_ids = '{0, 1, 2, 3, 0};
`else
        exp_ids = '{0, 0, 0, 0, 0};
`endif

        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        apply_reset();

        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_res", 32'(resp_res), 0);
        check("rst_resp_id", 32'(resp_id), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // All requesters continuously valid, consumer always ready.
        apply_reset();
        for (int i = 0; i < N; i++) set_slot(i, 32'(i), 32'd2, 1'b0);
        req_valid = '1;
        got  = 0;
        last = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                check($sformatf("arb_id%0d", got), 32'(resp_id), 32'(exp_ids[got]));
                check($sformatf("arb_res%0d", got), 32'(resp_res), 32'(exp_ids[got] < 2));
                if (got > 0) check($sformatf("arb_interval%0d", got), 32'(cyc - last), 3);
                last = cyc;
                got++;
                if (got == 5) break;
            end
        end
        req_valid = '0;
        check("arb_count", 32'(got), 5);
        repeat (3) @(posedge clk);
        #1;

        // Consumer stalls for 5 cycles while everyone keeps requesting.
        apply_reset();
        for (int i = 0; i < N; i++) set_slot(i, 32'(i), 32'd1, 1'b0);
        resp_ready = 1'b0;
        req_valid  = '1;
        n = 0;
        while (!resp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_resp_seen", 32'(resp_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", k), 32'(resp_valid), 1);
            check($sformatf("stall%0d_res", k), 32'(resp_res), 1);
            check($sformatf("stall%0d_id", k), 32'(resp_id), 0);
            check($sformatf("stall%0d_ready", k), 32'(req_ready), 0);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", 32'(resp_valid), 0);
        check("stall_release_busy", 32'(busy), 0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("stall_single_resp", 32'(seen), 0);

        // Reset pulse while a compare is in flight.
        @(posedge clk);
        #1;
        set_slot(1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        req_valid = '0;
        check("inflight_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(resp_valid), 0);
        check("midrst_res", 32'(resp_res), 0);
        check("midrst_id", 32'(resp_id), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid || busy) seen++;
        end
        check("midrst_no_resp", 32'(seen), 0);

        do_txn(vecs[6], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
